// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: fetch FSM states and
// the instruction word width.
package inst_fetch_pkg;

    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_queue.sv
// Synchronous circular FIFO of {pc, inst} entries. It has power-of-two depth,
// wrapping head/tail pointers and an explicit occupancy count.
module inst_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  logic [2*INST_WIDTH-1:0] push_data,
    output logic                    full,
    output logic                    empty,
    output logic [2*INST_WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [2*INST_WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [PTR_W:0]          count;
    logic                    do_push;
    logic                    do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = slots[head];

    always_ff @(posedge clk_in) begin
        if (!rst_in || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                tail <= tail + PTR_W'(1);
            if (do_pop)
                head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which slots are live.
    always_ff @(posedge clk_in) begin
        if (do_push && !clear)
            slots[tail] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage. It reads four bytes per instruction from the
// byte-wide memory port, assembles them little-endian and queues {pc, inst}
// for decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
)(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a_out,
    output logic        mem_req_out,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    fetch_state_e            state;
    fetch_state_e            state_next;
    logic [31:0]             pc;
    logic [31:0]             fetch_addr;
    logic [1:0]              issue_cnt;
    logic [1:0]              issue_cnt_next;
    logic [1:0]              recv_cnt;
    logic [23:0]             low_bytes;
    logic                    fetch_req;
    logic                    drain_push;
    logic                    q_push;
    logic                    q_pop;
    logic                    q_clear;
    logic                    q_full;
    logic                    q_empty;
    logic [2*INST_WIDTH-1:0] q_head;

    // Byte 0 goes out from IDLE, so one instruction costs five cycles in total.
    always_comb begin
        state_next     = state;
        issue_cnt_next = issue_cnt;
        fetch_req      = 1'b0;
        fetch_addr     = pc;
        drain_push     = 1'b0;
        case (state)
            IDLE: begin
                if (!q_full) begin
                    fetch_req      = 1'b1;
                    issue_cnt_next = 2'd1;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                fetch_req      = 1'b1;
                fetch_addr     = pc + {30'd0, issue_cnt};
                issue_cnt_next = issue_cnt + 2'd1;
                if (issue_cnt == 2'd3)
                    state_next = DRAIN;
            end
            DRAIN: begin
                drain_push = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign recv_cnt    = issue_cnt - 2'd1;
    assign mem_req_out = rst_in && rdy_in && fetch_req;
    assign mem_a_out   = mem_req_out ? fetch_addr : 32'd0;

    assign q_clear = rdy_in && flush_in;
    assign q_push  = rdy_in && !flush_in && drain_push;
    assign q_pop   = rdy_in && !flush_in && out_ready;

    // A pause or a flush abandons the partial word and restarts from IDLE.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            issue_cnt <= 2'd0;
            low_bytes <= 24'd0;
        end else if (!rdy_in) begin
            state     <= IDLE;
            issue_cnt <= 2'd0;
        end else if (flush_in) begin
            state     <= IDLE;
            pc        <= flush_pc_in;
            issue_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_cnt_next;
            if (state == FETCH) begin
                case (recv_cnt)
                    2'd0:    low_bytes[7:0]   <= mem_din;
                    2'd1:    low_bytes[15:8]  <= mem_din;
                    2'd2:    low_bytes[23:16] <= mem_din;
                    default: ;
                endcase
            end
            if (state == DRAIN)
                pc <= pc + 32'd4;
        end
    end

    inst_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (q_push),
        .pop       (q_pop),
        .clear     (q_clear),
        .push_data ({pc, mem_din, low_bytes}),
        .full      (q_full),
        .empty     (q_empty),
        .head_data (q_head)
    );

    assign out_valid = !q_empty;
    assign out_pc    = q_empty ? 32'd0 : q_head[2*INST_WIDTH-1:INST_WIDTH];
    assign out_inst  = q_empty ? 32'd0 : q_head[INST_WIDTH-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic,
// all compared against a transaction-level model of memory, fetch and queue.
module tb_inst_fetch;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'd0;
    logic [31:0] mem_a_out;
    logic        mem_req_out;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc_in = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_init = 0;
    logic [31:0] m_pc;
    bit          m_busy;
    int          m_phase;
    entry_t      m_q[$];

    logic        seen_req, seen_valid;
    logic [31:0] seen_addr, seen_pc, seen_inst;

    inst_fetch #(
        .QUEUE_DEPTH(DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .mem_din     (mem_din),
        .mem_a_out   (mem_a_out),
        .mem_req_out (mem_req_out),
        .flush_in    (flush_in),
        .flush_pc_in (flush_pc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'h0:   return 8'h93;
            32'h1:   return 8'h00;
            32'h2:   return 8'h10;
            32'h3:   return 8'h00;
            default: begin
                t = a[7:0] * 8'd7;
                return t ^ a[15:8] ^ a[31:24] ^ 8'h3C;
            end
        endcase
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model of one clock edge: an instruction is fetched as a whole transaction.
    task automatic modelAdvance();
        int sz;
        entry_t e;
        sz = m_q.size();
        if (!rst_in) begin
            m_init = 1; m_pc = 32'h0; m_busy = 0; m_phase = 0; m_q.delete();
        end else if (!m_init) begin
        end else if (!rdy_in) begin
            m_busy = 0;
        end else if (flush_in) begin
            m_q.delete(); m_pc = flush_pc_in; m_busy = 0;
        end else begin
            if (out_ready && sz > 0) void'(m_q.pop_front());
            if (!m_busy) begin
                if (sz < DEPTH) begin m_busy = 1; m_phase = 1; end
            end else if (m_phase < 4) begin
                m_phase++;
            end else begin
                e.pc = m_pc; e.inst = wordAt(m_pc);
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
                m_busy = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic fl,
                                 input logic [31:0] fpc, input logic ordy);
        logic        exp_req;
        logic [31:0] exp_addr;
        rst_in = r; rdy_in = rdy; flush_in = fl; flush_pc_in = fpc; out_ready = ordy;
        @(negedge clk_in);
        if (m_init) begin
            exp_req  = rst_in && rdy_in && (m_busy ? (m_phase < 4) : (m_q.size() < DEPTH));
            exp_addr = !exp_req ? 32'd0 : (m_busy ? m_pc + m_phase : m_pc);
            checkOutput("mem_req", {31'd0, mem_req_out}, {31'd0, exp_req});
            checkOutput("mem_a", mem_a_out, exp_addr);
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
            checkOutput("out_pc", out_pc, m_q.size() > 0 ? m_q[0].pc : 32'd0);
            checkOutput("out_inst", out_inst, m_q.size() > 0 ? m_q[0].inst : 32'd0);
        end
        seen_req = mem_req_out; seen_addr = mem_a_out;
        seen_valid = out_valid; seen_pc = out_pc; seen_inst = out_inst;
        modelAdvance();
        @(posedge clk_in);
        #1;
        mem_din = seen_req ? memByte(seen_addr) : 8'($urandom);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] next_pc;
        bit          got_req;

        // First instruction after reset
        doReset();
        checkOutput("reset_valid", {31'd0, seen_valid}, 32'd0);
        checkOutput("reset_req", {31'd0, seen_req}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            if (k <= 4) checkOutput("first_addr", seen_addr, 32'(k - 1));
        end
        checkOutput("first_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("first_inst", out_inst, 32'h00100093);
        checkOutput("first_pc", out_pc, 32'h0);

        // Back-pressure fills the queue, then drain in order
        doReset();
        for (int k = 0; k < 30; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("full_req", {31'd0, seen_req}, 32'd0);
        checkOutput("full_head", seen_pc, 32'h0);
        next_pc = 32'h0;
        got_req = 0;
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            if (seen_valid) begin
                checkOutput("drain_order", seen_pc, next_pc);
                next_pc = next_pc + 32'd4;
            end
            if (seen_req && !got_req) begin
                checkOutput("resume_addr", seen_addr, 32'h10);
                got_req = 1;
            end
        end
        checkOutput("drained_all", {31'd0, next_pc >= 32'h10}, 32'd1);

        // Flush while pc 0x8 is mid-fetch with two entries queued
        doReset();
        for (int k = 1; k <= 13; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("flush_valid", {31'd0, seen_valid}, 32'd0);
        checkOutput("flush_addr", seen_addr, 32'h100);
        for (int k = 16; k <= 19; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("flush_newpc", seen_pc, 32'h100);
        checkOutput("flush_newinst", seen_inst, wordAt(32'h100));

        // Flush coinciding with a DRAIN and a dequeue
        doReset();
        for (int k = 1; k <= 9; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("flush2_valid", {31'd0, seen_valid}, 32'd0);
        for (int k = 12; k <= 15; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("flush2_pc", seen_pc, 32'h200);

        // Pause mid-fetch at pc 0x4
        doReset();
        for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int k = 8; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("pause_req", {31'd0, seen_req}, 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("resume_pc4", seen_addr, 32'h4);
        for (int k = 12; k <= 15; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("pause_inst", seen_inst, wordAt(32'h4));

        // Fetch across the top of the address space, then reset mid-fetch
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("wrap_addr", seen_addr, 32'hFFFF_FFFC + 32'(i));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("wrap_next", seen_addr, 32'h0);
        checkOutput("wrap_pc", seen_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        doReset();
        checkOutput("midrst_req", {31'd0, seen_req}, 32'd0);
        checkOutput("midrst_addr", seen_addr, 32'd0);
        checkOutput("midrst_valid", {31'd0, seen_valid}, 32'd0);
        checkOutput("midrst_pc", seen_pc, 32'd0);
        checkOutput("midrst_inst", seen_inst, 32'd0);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            logic [31:0] fpc;
            fpc = $urandom();
            if ($urandom_range(0, 3) != 0) fpc[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 29) == 0, fpc, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
